// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and constants for the LC-3 SRAM-bus responder.
// Includes the boot program that is loaded when LC3_MEM_RESP_PRELOAD_EN is defined.
package lc3_mem_resp_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_HOLD
  } resp_state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;

  localparam int PROG_LEN = 8;

  // Small loop: R1 accumulates 5+4+3+2+1, then stores and reloads it through R2.
  function automatic logic [15:0] prog_rom(input int unsigned idx);
    case (idx)
      0:       prog_rom = {OP_AND, 3'd0, 3'd0, 1'b1, 5'd0};
      1:       prog_rom = {OP_ADD, 3'd0, 3'd0, 1'b1, 5'd5};
      2:       prog_rom = {OP_AND, 3'd1, 3'd1, 1'b1, 5'd0};
      3:       prog_rom = {OP_ADD, 3'd1, 3'd1, 3'b000, 3'd0};
      4:       prog_rom = {OP_ADD, 3'd0, 3'd0, 1'b1, 5'h1F};
      5:       prog_rom = {OP_BR, 3'b001, 9'h1FD};
      6:       prog_rom = {OP_STR, 3'd1, 3'd2, 6'd0};
      7:       prog_rom = {OP_LDR, 3'd3, 3'd2, 6'd0};
      default: prog_rom = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_responder_if.sv
// SRAM-style bus between the LC-3 control unit (master) and the memory responder (slave).
import lc3_mem_resp_pkg::*;

interface lc3_mem_responder_if #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              Rd_valid;
  logic              Wr_done;
  logic              Conflict;
  logic              Busy;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM,
    input  Data_from_SRAM, Rd_valid, Wr_done, Conflict, Busy
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_to_SRAM,
    output Data_from_SRAM, Rd_valid, Wr_done, Conflict, Busy
  );

endinterface

// File: rtl/lc3_mem_responder_array.sv
// DEPTH x DATA_W word store with independent byte-lane write enables and a
// registered read port that can be forced to zero for unmapped addresses.
module lc3_mem_array
  import lc3_mem_resp_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_en_hi,
  input  logic              wr_en_lo,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam int LANE_W = DATA_W / 2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en_hi) mem[wr_idx][DATA_W-1:LANE_W] <= wr_data[DATA_W-1:LANE_W];
    if (wr_en_lo) mem[wr_idx][LANE_W-1:0] <= wr_data[LANE_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// On-chip memory responder for the LC-3 SRAM bus (two-cycle read/write strobes).
// Define LC3_MEM_RESP_PRELOAD_EN to load the package boot program after every reset.
module lc3_mem_responder
  import lc3_mem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  lc3_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  resp_state_t       state;
  logic              rd_valid_q;
  logic              wr_done_q;
  logic              conflict_q;
  logic              sel, rd, wr, both;
  logic              mapped;
  logic [IDX_W-1:0]  addr_idx;
  logic              commit;
  logic              rd_load;
  logic              arr_wr_hi, arr_wr_lo;
  logic [IDX_W-1:0]  arr_wr_idx;
  logic [DATA_W-1:0] arr_wr_data;
  logic [DATA_W-1:0] arr_rd_data;

  assign sel      = ~bus.Mem_CE;
  assign rd       = sel & ~bus.Mem_OE &  bus.Mem_WE;
  assign wr       = sel & ~bus.Mem_WE &  bus.Mem_OE;
  assign both     = sel & ~bus.Mem_OE & ~bus.Mem_WE;
  assign mapped   = (bus.ADDR < ADDR_W'(DEPTH));
  assign addr_idx = bus.ADDR[IDX_W-1:0];

  // Reset at the commit edge must win, so the write strobe is gated here too.
  assign commit  = (state == ST_WR_SETUP) & wr & ~Reset;
  assign rd_load = ((state == ST_IDLE) | (state == ST_READ)) & rd;

`ifdef LC3_MEM_RESP_PRELOAD_EN
  logic [IDX_W-1:0] init_idx;
  logic             init_wr;
  logic             busy_q;

  assign init_wr     = (state == ST_INIT) & ~Reset;
  assign arr_wr_hi   = init_wr | (commit & ~bus.Mem_UB & mapped);
  assign arr_wr_lo   = init_wr | (commit & ~bus.Mem_LB & mapped);
  assign arr_wr_idx  = init_wr ? init_idx : addr_idx;
  assign arr_wr_data = init_wr ? DATA_W'(prog_rom(32'(init_idx))) : bus.Data_to_SRAM;
  assign bus.Busy    = busy_q;
`else
  assign arr_wr_hi   = commit & ~bus.Mem_UB & mapped;
  assign arr_wr_lo   = commit & ~bus.Mem_LB & mapped;
  assign arr_wr_idx  = addr_idx;
  assign arr_wr_data = bus.Data_to_SRAM;
  assign bus.Busy    = 1'b0;
`endif

  lc3_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en_hi (arr_wr_hi),
    .wr_en_lo (arr_wr_lo),
    .wr_idx   (arr_wr_idx),
    .wr_data  (arr_wr_data),
    .rd_en    (rd_load),
    .rd_zero  (~mapped),
    .rd_idx   (addr_idx),
    .rd_data  (arr_rd_data)
  );

  // A write commits only on the second WE-low edge; WR_HOLD swallows the rest of the strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
`ifdef LC3_MEM_RESP_PRELOAD_EN
      state    <= ST_INIT;
      init_idx <= '0;
      busy_q   <= 1'b1;
`else
      state    <= ST_IDLE;
`endif
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      unique case (state)
`ifdef LC3_MEM_RESP_PRELOAD_EN
        ST_INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (init_idx == IDX_W'(PROG_LEN - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
`endif
        ST_IDLE: begin
          if (both) begin
            conflict_q <= 1'b1;
          end else if (rd) begin
            state      <= ST_READ;
            rd_valid_q <= 1'b1;
          end else if (wr) begin
            state <= ST_WR_SETUP;
          end
        end
        ST_READ: begin
          if (both) begin
            conflict_q <= 1'b1;
            state      <= ST_IDLE;
            rd_valid_q <= 1'b0;
          end else if (!rd) begin
            state      <= ST_IDLE;
            rd_valid_q <= 1'b0;
          end
        end
        ST_WR_SETUP: begin
          if (both) begin
            conflict_q <= 1'b1;
            state      <= ST_IDLE;
          end else if (wr) begin
            state     <= ST_WR_HOLD;
            wr_done_q <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WR_HOLD: begin
          if (both) begin
            conflict_q <= 1'b1;
            state      <= ST_IDLE;
          end else if (!wr) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Data_from_SRAM = arr_rd_data;
  assign bus.Rd_valid       = rd_valid_q;
  assign bus.Wr_done        = wr_done_q;
  assign bus.Conflict       = conflict_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed scenarios plus randomized
// traffic against a word-level memory model (boot checks when LC3_MEM_RESP_PRELOAD_EN is set).
module tb_lc3_mem_responder;

  localparam int TB_DEPTH    = 256;
  localparam int TB_PROG_LEN = 8;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] model_mem [int];
  logic [19:0] pool [8];
  logic [15:0] boot_words [TB_PROG_LEN] = '{16'h5020, 16'h1025, 16'h5260, 16'h1240,
                                            16'h103F, 16'h03FD, 16'h7280, 16'h6680};

  always #5 Clk = ~Clk;

  lc3_mem_responder_if bus ();

  lc3_mem_responder dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic bus_idle();
    bus.Mem_CE = 1'b1;
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b1;
    bus.Mem_UB = 1'b1;
    bus.Mem_LB = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_init();
`ifdef LC3_MEM_RESP_PRELOAD_EN
    repeat (TB_PROG_LEN) @(negedge Clk);
`endif
  endtask

  function automatic void model_write(input logic [19:0] a, input logic [15:0] d,
                                      input logic ub, input logic lb);
    logic [15:0] w;
    if (a < 20'(TB_DEPTH)) begin
      w = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 16'h0000;
      if (!ub) w[15:8] = d[15:8];
      if (!lb) w[7:0]  = d[7:0];
      model_mem[int'(a)] = w;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [19:0] a);
    if (a >= 20'(TB_DEPTH) || !model_mem.exists(int'(a))) return 16'h0000;
    return model_mem[int'(a)];
  endfunction

  // Drives WE low for we_cycles cycles, then counts Wr_done pulses seen.
  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic ub,
                          input logic lb, input int we_cycles, output int pulses);
    pulses = 0;
    bus.ADDR = a;
    bus.Data_to_SRAM = d;
    bus.Mem_UB = ub;
    bus.Mem_LB = lb;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b0;
    for (int i = 0; i < we_cycles; i++) begin
      @(negedge Clk);
      if (bus.Wr_done === 1'b1) pulses++;
    end
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (bus.Wr_done === 1'b1) pulses++;
    end
  endtask

  // Two-cycle OE strobe; data/valid are sampled in the second OE-low cycle.
  task automatic do_read(input logic [19:0] a, output logic [15:0] d, output logic v);
    bus.ADDR = a;
    bus.Mem_CE = 1'b0;
    bus.Mem_WE = 1'b1;
    bus.Mem_OE = 1'b0;
    @(negedge Clk);
    d = bus.Data_from_SRAM;
    v = bus.Rd_valid;
    @(negedge Clk);
    bus_idle();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus_idle();
    bus.ADDR = '0;
    bus.Data_to_SRAM = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    n_checks++;
    if (bus.Data_from_SRAM !== 16'h0000 || bus.Rd_valid !== 1'b0 ||
        bus.Wr_done !== 1'b0 || bus.Conflict !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got data=%h rv=%b wd=%b cf=%b required 0000/0/0/0",
               bus.Data_from_SRAM, bus.Rd_valid, bus.Wr_done, bus.Conflict);
    end
    n_checks++;
`ifdef LC3_MEM_RESP_PRELOAD_EN
    if (bus.Busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b required 1", bus.Busy);
    end
`else
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_busy: got %b required 0", bus.Busy);
    end
`endif
    wait_init();
  endtask

  task automatic test_write_read();
    int p;
    logic [15:0] d;
    logic v;
    do_write(20'h00012, 16'hBEEF, 1'b0, 1'b0, 2, p);
    model_write(20'h00012, 16'hBEEF, 1'b0, 1'b0);
    n_checks++;
    if (p !== 1) begin
      n_fail++;
      $display("[TB] FAIL write_pulse: got %0d pulses required 1", p);
    end
    do_read(20'h00012, d, v);
    n_checks++;
    if (d !== model_read(20'h00012) || v !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL read_beef: got %h valid=%b required %h valid=1", d, v,
               model_read(20'h00012));
    end
    n_checks++;
    if (bus.Rd_valid !== 1'b0 || bus.Data_from_SRAM !== 16'hBEEF) begin
      n_fail++;
      $display("[TB] FAIL read_release: got rv=%b data=%h required rv=0 data=beef",
               bus.Rd_valid, bus.Data_from_SRAM);
    end
  endtask

  task automatic test_byte_lane();
    int p;
    logic [15:0] d;
    logic v;
    do_write(20'h00012, 16'h1234, 1'b1, 1'b0, 2, p);
    model_write(20'h00012, 16'h1234, 1'b1, 1'b0);
    n_checks++;
    if (p !== 1) begin
      n_fail++;
      $display("[TB] FAIL lane_pulse: got %0d pulses required 1", p);
    end
    do_read(20'h00012, d, v);
    n_checks++;
    if (d !== model_read(20'h00012)) begin
      n_fail++;
      $display("[TB] FAIL lane_read: got %h required %h", d, model_read(20'h00012));
    end
  endtask

  task automatic test_abort();
    int p;
    logic [15:0] d;
    logic v;
    do_write(20'h00012, 16'h0000, 1'b0, 1'b0, 1, p);
    n_checks++;
    if (p !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_pulse: got %0d pulses required 0", p);
    end
    do_read(20'h00012, d, v);
    n_checks++;
    if (d !== model_read(20'h00012)) begin
      n_fail++;
      $display("[TB] FAIL abort_read: got %h required %h", d, model_read(20'h00012));
    end
  endtask

  task automatic test_conflict();
    logic [15:0] d;
    logic v;
    bus.ADDR = 20'h00012;
    bus.Data_to_SRAM = 16'hFFFF;
    bus.Mem_UB = 1'b0;
    bus.Mem_LB = 1'b0;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = 1'b0;
    bus.Mem_WE = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (bus.Conflict !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL conflict_set: got %b required 1", bus.Conflict);
    end
    repeat (2) @(negedge Clk);
    bus_idle();
    repeat (3) @(negedge Clk);
    n_checks++;
    if (bus.Conflict !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL conflict_sticky: got %b required 1", bus.Conflict);
    end
    do_read(20'h00012, d, v);
    n_checks++;
    if (d !== model_read(20'h00012)) begin
      n_fail++;
      $display("[TB] FAIL conflict_mem: got %h required %h", d, model_read(20'h00012));
    end
    pulse_reset();
    n_checks++;
    if (bus.Conflict !== 1'b0 || bus.Data_from_SRAM !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL conflict_clear: got cf=%b data=%h required 0/0000",
               bus.Conflict, bus.Data_from_SRAM);
    end
    wait_init();
    do_read(20'h00012, d, v);
    n_checks++;
    if (d !== model_read(20'h00012)) begin
      n_fail++;
      $display("[TB] FAIL reset_keeps_mem: got %h required %h", d, model_read(20'h00012));
    end
    // Conflict raised from within a read.
    bus.ADDR = 20'h00012;
    bus.Mem_CE = 1'b0;
    bus.Mem_WE = 1'b1;
    bus.Mem_OE = 1'b0;
    @(negedge Clk);
    bus.Mem_WE = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (bus.Conflict !== 1'b1 || bus.Rd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL conflict_in_read: got cf=%b rv=%b required 1/0",
               bus.Conflict, bus.Rd_valid);
    end
    bus_idle();
    pulse_reset();
    wait_init();
  endtask

  task automatic test_reset_write();
    logic [15:0] d;
    logic v;
    bus.ADDR = 20'h00012;
    bus.Data_to_SRAM = 16'h7777;
    bus.Mem_UB = 1'b0;
    bus.Mem_LB = 1'b0;
    bus.Mem_CE = 1'b0;
    bus.Mem_OE = 1'b1;
    bus.Mem_WE = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus_idle();
    n_checks++;
    if (bus.Wr_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_drop_pulse: got %b required 0", bus.Wr_done);
    end
    wait_init();
    do_read(20'h00012, d, v);
    n_checks++;
    if (d !== model_read(20'h00012)) begin
      n_fail++;
      $display("[TB] FAIL reset_drop_write: got %h required %h", d, model_read(20'h00012));
    end
  endtask

  task automatic test_unmapped();
    int p;
    logic [15:0] d;
    logic v;
    do_write(20'h00000, 16'h5A5A, 1'b0, 1'b0, 2, p);
    model_write(20'h00000, 16'h5A5A, 1'b0, 1'b0);
    do_read(20'h00100, d, v);
    n_checks++;
    if (d !== 16'h0000 || v !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL unmapped_read: got %h valid=%b required 0000 valid=1", d, v);
    end
    do_write(20'h00100, 16'hAAAA, 1'b0, 1'b0, 2, p);
    model_write(20'h00100, 16'hAAAA, 1'b0, 1'b0);
    n_checks++;
    if (p !== 1) begin
      n_fail++;
      $display("[TB] FAIL unmapped_pulse: got %0d pulses required 1", p);
    end
    do_read(20'h00000, d, v);
    n_checks++;
    if (d !== model_read(20'h00000)) begin
      n_fail++;
      $display("[TB] FAIL unmapped_alias: got %h required %h", d, model_read(20'h00000));
    end
  endtask

  task automatic test_random();
    int p;
    logic [15:0] d, wd;
    logic v, ub, lb;
    logic [19:0] a;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 20'(32 + i * 28 + $urandom_range(0, 27));
      wd = 16'($urandom);
      do_write(pool[i], wd, 1'b0, 1'b0, 2, p);
      model_write(pool[i], wd, 1'b0, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          a  = pool[$urandom_range(0, 7)];
          wd = 16'($urandom);
          ub = 1'($urandom);
          lb = 1'($urandom);
          do_write(a, wd, ub, lb, $urandom_range(2, 4), p);
          model_write(a, wd, ub, lb);
          n_checks++;
          if (p !== 1) begin
            n_fail++;
            $display("[TB] FAIL rand_write_pulse: addr %h got %0d pulses required 1", a, p);
          end
        end
        1: begin
          a = pool[$urandom_range(0, 7)];
          do_read(a, d, v);
          n_checks++;
          if (d !== model_read(a) || v !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rand_read: addr %h got %h valid=%b required %h valid=1",
                     a, d, v, model_read(a));
          end
        end
        default: begin
          a = 20'($urandom_range(TB_DEPTH, 20'hFFFFF));
          do_read(a, d, v);
          n_checks++;
          if (d !== 16'h0000 || v !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rand_unmapped: addr %h got %h valid=%b required 0000 valid=1",
                     a, d, v);
          end
        end
      endcase
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] cur;
    cur = pool[0];
    bus.ADDR = cur;
    bus.Mem_CE = 1'b0;
    bus.Mem_WE = 1'b1;
    bus.Mem_OE = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      n_checks++;
      if (bus.Data_from_SRAM !== model_read(cur) || bus.Rd_valid !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL track_read: addr %h got %h valid=%b required %h valid=1",
                 cur, bus.Data_from_SRAM, bus.Rd_valid, model_read(cur));
      end
      cur = pool[$urandom_range(0, 7)];
      bus.ADDR = cur;
    end
    bus_idle();
    @(negedge Clk);
  endtask

`ifdef LC3_MEM_RESP_PRELOAD_EN
  task automatic test_preload();
    logic [15:0] d;
    logic v;
    logic [19:0] a;
    pulse_reset();
    repeat (3) @(negedge Clk);
    pulse_reset();
    for (int i = 0; i < TB_PROG_LEN; i++) begin
      n_checks++;
      if (bus.Busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL preload_busy: cycle %0d got %b required 1", i, bus.Busy);
      end
      @(negedge Clk);
    end
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL preload_done: got %b required 0", bus.Busy);
    end
    for (int i = 0; i < TB_PROG_LEN; i++) begin
      a = 20'(i);
      model_mem[i] = boot_words[i];
      do_read(a, d, v);
      n_checks++;
      if (d !== model_read(a)) begin
        n_fail++;
        $display("[TB] FAIL preload_word: addr %0d got %h required %h", i, d, model_read(a));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_lane();
    test_abort();
    test_conflict();
    test_reset_write();
    test_unmapped();
    test_random();
    test_back_to_back();
`ifdef LC3_MEM_RESP_PRELOAD_EN
    test_preload();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
